// File: rtl/hms_pkg.sv
// hms_pkg: shared mode/position encodings and blink-mask layout for the hms clock controller
package hms_pkg;
  typedef enum logic {MODE_CLOCK = 1'b0, MODE_SETUP = 1'b1} mode_e;
  typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2} pos_e;
  localparam int BLK_SEC  = 0;
  localparam int BLK_MIN  = 2;
  localparam int BLK_HOUR = 4;
  function automatic pos_e next_pos(input pos_e p);
    return p == POS_HOUR ? POS_SEC : p == POS_MIN ? POS_HOUR : POS_MIN;
  endfunction
  function automatic int blk_idx(input pos_e p);
    return p == POS_HOUR ? BLK_HOUR : p == POS_MIN ? BLK_MIN : BLK_SEC;
  endfunction
endpackage

// File: rtl/hms_ctrl_strb_gen.sv
// strb_gen: divider emitting a one-cycle strobe every P_DIV cycles; clr_i holds the count at zero
module strb_gen #(
  parameter int P_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic strb_o
);
  localparam int W = P_DIV > 1 ? $clog2(P_DIV) : 1;
  localparam logic [W-1:0] TC = W'(P_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign strb_o = (cnt_q == TC) && !clr_i;
  assign cnt_d  = (clr_i || cnt_q == TC) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/hms_ctrl.sv
// hms_ctrl: button-driven mode/position/increment control and 1 Hz tick carry chain for an h:m:s clock
module hms_ctrl
  import hms_pkg::*;
#(
  parameter int P_TICK_DIV  = 50000000,
  parameter int P_DEB_DIV   = 500000,
  parameter int P_BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_at_max,
  input  logic       i_min_at_max,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic [5:0] o_blink_mask
);
  logic smp_strb, tick_strb, blink_strb, blink_clr, smp_d_q, phase_q, setup, inc_set;
  logic [2:0] sw, old_q, new_q, press;
  mode_e mode_q, mode_d;
  pos_e pos_q, pos_d;
  assign sw    = {i_sw2, i_sw1, i_sw0};
  // a press is a 1->0 step in the sampled history, seen only in the cycle after the sample
  assign press = {3{smp_d_q}} & old_q & ~new_q;
  assign setup = mode_q == MODE_SETUP;
  assign inc_set   = setup && press[2] && !press[0];
  assign blink_clr = !setup || press[2] || press[1];
  strb_gen #(.P_DIV(P_DEB_DIV))   u_smp   (.clk(clk), .rst_n(rst_n), .clr_i(1'b0),      .strb_o(smp_strb));
  strb_gen #(.P_DIV(P_TICK_DIV))  u_tick  (.clk(clk), .rst_n(rst_n), .clr_i(setup),     .strb_o(tick_strb));
  strb_gen #(.P_DIV(P_BLINK_DIV)) u_blink (.clk(clk), .rst_n(rst_n), .clr_i(blink_clr), .strb_o(blink_strb));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      old_q   <= '1;
      new_q   <= '1;
      smp_d_q <= 1'b0;
      phase_q <= 1'b0;
      mode_q  <= MODE_CLOCK;
      pos_q   <= POS_SEC;
    end else begin
      smp_d_q <= smp_strb;
      if (smp_strb) begin
        old_q <= new_q;
        new_q <= sw;
      end
      phase_q <= blink_clr ? 1'b0 : phase_q ^ blink_strb;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
    end
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    if (press[0]) begin
      mode_d = setup ? MODE_CLOCK : MODE_SETUP;
      pos_d  = setup ? pos_q : POS_SEC;
    end else if (setup && press[1]) pos_d = next_pos(pos_q);
  end
  assign o_sec_inc    = setup ? inc_set && pos_q == POS_SEC  : tick_strb;
  assign o_min_inc    = setup ? inc_set && pos_q == POS_MIN  : tick_strb && i_sec_at_max;
  assign o_hour_inc   = setup ? inc_set && pos_q == POS_HOUR : tick_strb && i_sec_at_max && i_min_at_max;
  assign o_mode       = mode_q;
  assign o_position   = pos_q;
  assign o_blink_mask = (setup && phase_q) ? 6'b000011 << blk_idx(pos_q) : 6'b0;
endmodule

// File: tb/tb_hms_ctrl.sv
// tb_hms_ctrl: scenario tasks plus randomized stimulus checked against a cycle-count reference model
module tb_hms_ctrl;
  localparam int TD = 10, DD = 4, BD = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_sw0 = 1'b1, i_sw1 = 1'b1, i_sw2 = 1'b1, i_sec_at_max = 1'b0, i_min_at_max = 1'b0;
  logic o_sec_inc, o_min_inc, o_hour_inc, o_mode;
  logic [1:0] o_position;
  logic [5:0] o_blink_mask;
  logic [11:0] act_o, exp_o;
  logic [2:0] cur_sw, hist, ev;
  int checks = 0, errors = 0;
  int n, tref, bref, m_pos;
  bit m_setup;
  assign act_o = {o_sec_inc, o_min_inc, o_hour_inc, o_mode, o_position, o_blink_mask};
  always #5 clk = ~clk;
  hms_ctrl #(.P_TICK_DIV(TD), .P_DEB_DIV(DD), .P_BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .i_sw0(i_sw0), .i_sw1(i_sw1), .i_sw2(i_sw2),
    .i_sec_at_max(i_sec_at_max), .i_min_at_max(i_min_at_max),
    .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc), .o_hour_inc(o_hour_inc),
    .o_mode(o_mode), .o_position(o_position), .o_blink_mask(o_blink_mask));

  // n counts cycles since reset release; tref/bref are the cycles at which tick/blink timing restarted
  task automatic model_reset();
    n = 0; tref = 0; bref = 0; m_setup = 1'b0; m_pos = 0; hist = 3'b111; ev = 3'b000;
  endtask

  task automatic drive(input logic [2:0] sw, input logic sm, input logic mm);
    logic tick, inc_ok;
    logic [5:0] mask;
    {i_sw2, i_sw1, i_sw0} = sw; i_sec_at_max = sm; i_min_at_max = mm; cur_sw = sw;
    #1;
    tick   = !m_setup && (n - tref) % TD == TD - 1;
    inc_ok = m_setup && ev[2] && !ev[0];
    mask   = (m_setup && ((n - bref) / BD) % 2 == 1) ? 6'b000011 << (2 * m_pos) : 6'b0;
    exp_o  = m_setup ? {inc_ok && m_pos == 0, inc_ok && m_pos == 1, inc_ok && m_pos == 2, 1'b1, 2'(m_pos), mask}
                     : {tick, tick && sm, tick && sm && mm, 1'b0, 2'(m_pos), 6'b0};
  endtask

  task automatic advance();
    logic [2:0] nev;
    nev = (n % DD == DD - 1) ? hist & ~cur_sw : 3'b000;
    if (n % DD == DD - 1) hist = cur_sw;
    if (ev[0]) begin
      if (!m_setup) begin m_setup = 1'b1; m_pos = 0; bref = n + 1; end
      else begin m_setup = 1'b0; tref = n + 1; end
    end else if (m_setup) begin
      if (ev[1]) m_pos = (m_pos + 1) % 3;
      if (ev[1] || ev[2]) bref = n + 1;
    end
    ev = nev; n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_sw2 = 1'b0; i_sec_at_max = 1'b1; i_min_at_max = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      if (act_o !== 12'b0) begin errors++; $display("FAIL reset_state got=%b exp=%b", act_o, 12'b0); end
      checks++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_tick();
    int cnt = 0, first = -1;
    for (int k = 0; k < 35; k++) begin
      drive(3'b111, 1'b0, 1'b0);
      if (act_o !== exp_o) begin errors++; $display("FAIL tick n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      if (o_sec_inc === 1'b1) begin cnt++; if (first < 0) first = n + 1; end
      advance();
    end
    if (first !== 10) begin errors++; $display("FAIL first_tick got=%0d exp=10", first); end
    checks++;
    if (cnt !== 3) begin errors++; $display("FAIL tick_count got=%0d exp=3", cnt); end
    checks++;
  endtask

  task automatic test_carry();
    int triple = 0, partial = 0;
    for (int k = 0; k < 30; k++) begin
      drive(3'b111, 1'b1, 1'b1);
      if (act_o !== exp_o) begin errors++; $display("FAIL carry n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      if (o_sec_inc && o_min_inc && o_hour_inc) triple++;
      else if (o_sec_inc || o_min_inc || o_hour_inc) partial++;
      advance();
    end
    if (triple !== 3 || partial !== 0) begin
      errors++; $display("FAIL carry_all got=%0d/%0d exp=3/0", triple, partial);
    end
    checks++;
    for (int k = 0; k < 40; k++) begin
      drive(3'b111, 1'($urandom % 2), 1'($urandom % 2));
      if (act_o !== exp_o) begin errors++; $display("FAIL carry_rand n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      advance();
    end
  endtask

  task automatic test_mode_hold();
    int toggles = 0, sec_setup = 0;
    logic prev = o_mode;
    for (int k = 0; k < 48; k++) begin
      drive(k < 40 ? 3'b110 : 3'b111, 1'b0, 1'b0);
      if (act_o !== exp_o) begin errors++; $display("FAIL mode_hold n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      if (o_mode !== prev) toggles++;
      if (o_mode === 1'b1 && o_sec_inc === 1'b1) sec_setup++;
      prev = o_mode;
      advance();
    end
    if (toggles !== 1 || o_mode !== 1'b1 || o_position !== 2'd0 || sec_setup !== 0) begin
      errors++;
      $display("FAIL mode_hold_sum got=t%0d m%b p%0d s%0d exp=t1 m1 p0 s0", toggles, o_mode, o_position, sec_setup);
    end
    checks++;
  endtask

  task automatic test_setup_edit();
    int hours = 0, others = 0, lit = 0;
    bit after = 1'b0;
    logic [2:0] sw;
    for (int k = 0; k < 72; k++) begin
      sw = (k < 8 || (k >= 16 && k < 24)) ? 3'b101 : (k >= 32 && k < 40) ? 3'b011 : 3'b111;
      drive(sw, 1'($urandom % 2), 1'($urandom % 2));
      if (act_o !== exp_o) begin errors++; $display("FAIL setup_edit n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      if (after) begin
        if (o_blink_mask !== 6'b0) begin errors++; $display("FAIL mask_after_press got=%b exp=%b", o_blink_mask, 6'b0); end
        checks++;
        after = 1'b0;
      end
      if (o_hour_inc === 1'b1) begin hours++; after = 1'b1; end
      if (o_sec_inc === 1'b1 || o_min_inc === 1'b1) others++;
      if (o_blink_mask === 6'b110000) lit++;
      advance();
    end
    if (o_position !== 2'd2 || hours !== 1 || others !== 0 || lit < 6) begin
      errors++;
      $display("FAIL setup_edit_sum got=p%0d h%0d o%0d lit%0d exp=p2 h1 o0 lit>=6", o_position, hours, others, lit);
    end
    checks++;
  endtask

  task automatic test_mode_inc_same();
    int mc = -1, sc = -1, incs = 0;
    for (int k = 0; k < 30; k++) begin
      drive(k < 8 ? 3'b010 : 3'b111, 1'b0, 1'b0);
      if (act_o !== exp_o) begin errors++; $display("FAIL mode_inc n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      if (mc < 0 && o_mode === 1'b0) mc = n;
      if (sc < 0 && o_sec_inc === 1'b1) sc = n;
      if (sc < 0 && (o_min_inc === 1'b1 || o_hour_inc === 1'b1)) incs++;
      advance();
    end
    if (mc < 0 || sc - (mc - 1) !== 10 || incs !== 0) begin
      errors++; $display("FAIL mode_inc_sum got=d%0d i%0d exp=d10 i0", sc - (mc - 1), incs);
    end
    checks++;
  endtask

  task automatic test_reset_mid_press();
    int secs = 0, others = 0;
    for (int k = 0; k < 22; k++) begin
      drive(k < 8 ? 3'b110 : k < 16 ? 3'b111 : 3'b011, 1'b1, 1'b1);
      if (act_o !== exp_o) begin errors++; $display("FAIL pre_reset n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      advance();
    end
    rst_n = 1'b0;
    repeat (3) begin
      #1;
      if (act_o !== 12'b0) begin errors++; $display("FAIL mid_reset got=%b exp=%b", act_o, 12'b0); end
      checks++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 25; k++) begin
      drive(3'b011, 1'b0, 1'b0);
      if (act_o !== exp_o) begin errors++; $display("FAIL post_reset n=%0d got=%b exp=%b", n, act_o, exp_o); end
      checks++;
      if (o_sec_inc === 1'b1) secs++;
      if (o_min_inc === 1'b1 || o_hour_inc === 1'b1) others++;
      advance();
    end
    if (secs !== 2 || others !== 0) begin
      errors++; $display("FAIL post_reset_sum got=s%0d o%0d exp=s2 o0", secs, others);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [2:0] sw;
    int len;
    for (int k = 0; k < 60; k++) begin
      sw  = {1'($urandom % 4 != 0), 1'($urandom % 4 != 0), 1'($urandom % 4 != 0)};
      len = $urandom_range(3, 12);
      for (int j = 0; j < len; j++) begin
        drive(sw, 1'($urandom % 2), 1'($urandom % 2));
        if (act_o !== exp_o) begin errors++; $display("FAIL random n=%0d got=%b exp=%b", n, act_o, exp_o); end
        checks++;
        advance();
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_carry();
    test_mode_hold();
    test_setup_edit();
    test_mode_inc_same();
    test_reset_mid_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hms_ctrl.md
HMS_CTRL -- requirements
Module: hms_ctrl

Interface
REQ-001 Parameter P_TICK_DIV, default 50000000: clk cycles per 1 Hz timekeeping tick.
REQ-002 Parameter P_DEB_DIV, default 500000: clk cycles per button sample strobe (100 Hz).
REQ-003 Parameter P_BLINK_DIV, default 25000000: clk cycles per blink phase toggle.
REQ-004 clk  input  1  sole clock, 50 MHz.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_sw0  input  1  mode button, active-low (1 = released).
REQ-007 i_sw1  input  1  position button, active-low.
REQ-008 i_sw2  input  1  increment button, active-low.
REQ-009 i_sec_at_max  input  1  level: seconds counter currently holds 59.
REQ-010 i_min_at_max  input  1  level: minutes counter currently holds 59.
REQ-011 o_sec_inc  output  1  one-cycle enable: seconds counter advances.
REQ-012 o_min_inc  output  1  one-cycle enable: minutes counter advances.
REQ-013 o_hour_inc  output  1  one-cycle enable: hours counter advances.
REQ-014 o_mode  output  1  0 = CLOCK, 1 = SETUP.
REQ-015 o_position  output  2  0 = SEC, 1 = MIN, 2 = HOUR; 3 never driven.
REQ-016 o_blink_mask  output  6  1 = blank digit; [1:0] sec, [3:2] min, [5:4] hour.

Function
REQ-017 All outputs and state are synchronous to clk; no output is ever used as a clock; inc outputs are enables only.
REQ-018 Sample strobe: one-cycle pulse every P_DEB_DIV cycles, free-running in both modes.
REQ-019 Each button: two-stage sample history loaded only on sample strobe; press event = one-cycle pulse in the clk cycle after the strobe on which history becomes (older=1, newer=0).
REQ-020 Holding a button produces exactly one press event; release produces none.
REQ-021 Mode press toggles o_mode; entering SETUP forces o_position to SEC in the same cycle.
REQ-022 Position press in SETUP advances o_position SEC->MIN->HOUR->SEC; ignored in CLOCK.
REQ-023 CLOCK: tick counter counts 0..P_TICK_DIV-1; at terminal count o_sec_inc=1 for one cycle.
REQ-024 CLOCK carry, same cycle as tick: o_min_inc = tick AND i_sec_at_max; o_hour_inc = tick AND i_sec_at_max AND i_min_at_max.
REQ-025 SETUP: tick counter held at 0; the first tick after returning to CLOCK arrives exactly P_TICK_DIV cycles after the mode change.
REQ-026 SETUP increment press: one-cycle pulse on the inc output of the current o_position only; no carry, at_max inputs ignored.
REQ-027 Increment press in CLOCK is ignored.
REQ-028 Simultaneous mode+increment press: mode action taken, increment dropped.
REQ-029 Simultaneous position+increment press: increment applies to the position held before advancing.
REQ-030 Blink: SETUP only; phase toggles every P_BLINK_DIV cycles; mask bits of selected pair = phase, others 0.
REQ-031 Increment or position press in SETUP clears blink phase and counter (digits visible immediately).
REQ-032 CLOCK: o_blink_mask = 0, blink counter and phase held at 0.
REQ-033 At most one inc output is asserted per cycle in SETUP; in CLOCK only the REQ-024 combinations occur.

Reset
REQ-034 rst_n low: o_mode=CLOCK, o_position=SEC, all inc outputs 0, o_blink_mask=0, all counters 0, blink phase 0, all sample history bits 1.
REQ-035 Reset mid-press or mid-tick discards the pending event; no inc pulse is emitted in the cycle reset releases.

Structure
REQ-036 Shared package hms_pkg holds MODE_CLOCK/MODE_SETUP, POS_SEC/POS_MIN/POS_HOUR and the blink-mask bit-pair indices.
REQ-037 One sub-module strb_gen (parameterised divider, clear input, one-cycle strobe output) is instantiated for tick, sample and blink timing.

Verification (P_TICK_DIV=10, P_DEB_DIV=4, P_BLINK_DIV=6)
REQ-038 Reset release, no buttons -> o_sec_inc pulses every 10 cycles, first on cycle 10; o_min_inc/o_hour_inc stay 0.
REQ-039 CLOCK, i_sec_at_max=1, i_min_at_max=1 at tick -> o_sec_inc, o_min_inc, o_hour_inc all 1 in the same single cycle.
REQ-040 Hold i_sw0 low 40 cycles -> exactly one mode toggle to SETUP, o_position=0, no o_sec_inc while held in SETUP.
REQ-041 SETUP, press i_sw1 twice then i_sw2 -> o_position=2, single o_hour_inc pulse, o_blink_mask toggles 6'b110000/0 every 6 cycles and reads 0 right after the press.
REQ-042 SETUP, i_sw0 and i_sw2 fall in the same sample -> mode returns to CLOCK, no inc pulse; next o_sec_inc exactly 10 cycles later.
REQ-043 Assert rst_n low while i_sw2 held in SETUP -> all outputs at reset values; no inc pulse after release until a fresh press or tick.
